// File: rtl/riscv_lsu.sv
// riscv_lsu - RV32I load/store unit sitting behind the ALU.
//
// Takes the ALU result as the effective address plus rs2 as store data and
// runs a single request/grant/rvalid transaction on the data-memory port.
// Loads return lane-extracted, sign/zero-extended data tagged with rd. Only
// one access is in flight; req_ready stays low until the unit is idle again.
// Misaligned accesses and unsupported funct3 codes never reach memory; they
// produce a one-cycle err pulse instead.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      issue handshake from the execute stage
//   req_we, req_funct3         store flag and RV32I width/sign code
//   req_addr, req_wdata        effective address and rs2 store data
//   req_rd                     destination register tag for loads
//   mem_req / mem_gnt          memory request, held until granted
//   mem_addr, mem_we           word-aligned address and write enable
//   mem_be, mem_wdata          byte enables and lane-replicated store data
//   mem_rvalid, mem_rdata      returned load word
//   rsp_valid, rsp_rd          one-cycle completion pulse and rd tag
//   rsp_data                   extended load data (0 for stores)
//   err                        one-cycle pulse for a rejected request

module riscv_lsu #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [4:0]             req_rd,
  output logic                   mem_req,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   rsp_valid,
  output logic [4:0]             rsp_rd,
  output logic [WORD_LENGTH-1:0] rsp_data,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             offset_q, offset_d;
  logic [4:0]             rd_q, rd_d;
  logic [4:0]             rsp_rd_q, rsp_rd_d;
  logic [WORD_LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   illegal;
  logic [3:0]             store_be;
  logic [WORD_LENGTH-1:0] store_wdata;
  logic [7:0]             load_byte;
  logic [15:0]            load_half;
  logic [WORD_LENGTH-1:0] load_ext;

  assign accept = req_valid && req_ready;

  // Legality of the incoming request: unsupported width codes and accesses
  // not naturally aligned to their size are rejected before any memory access.
  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  illegal = 1'b0;
        3'b001:  illegal = req_addr[0];
        3'b010:  illegal = |req_addr[1:0];
        default: illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = req_addr[0];
        3'b010:         illegal = |req_addr[1:0];
        default:        illegal = 1'b1;
      endcase
    end
  end

  // Store data is replicated across every lane so memory only has to honour
  // the byte enables; loads always read the full word.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          store_be    = 4'b0001 << req_addr[1:0];
          store_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          store_be    = 4'b0011 << {req_addr[1], 1'b0};
          store_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          store_be    = 4'b1111;
          store_wdata = req_wdata;
        end
      endcase
    end
  end

  // Lane selection and extension of the returned word, using the offset and
  // width captured when the request was accepted.
  always_comb begin
    case (offset_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'd0, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An illegal request is consumed in IDLE without leaving it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !illegal) state_d = REQ;
      REQ:  if (mem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = (state_q == REQ);
    mem_we    = (state_q == REQ) && we_q;
    rsp_valid = (state_q == RESP);
  end

  // Request capture and response formation. Captured fields stay untouched
  // while a transaction is pending, which keeps the memory port stable.
  always_comb begin
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    rd_d       = rd_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_data_d = rsp_data_q;
    err_d      = 1'b0;
    if (accept) begin
      if (illegal) begin
        err_d = 1'b1;
      end else begin
        addr_d   = {req_addr[WORD_LENGTH-1:2], 2'b00};
        be_d     = store_be;
        wdata_d  = store_wdata;
        we_d     = req_we;
        funct3_d = req_funct3;
        offset_d = req_addr[1:0];
        rd_d     = req_rd;
      end
    end
    if (state_q == REQ && mem_gnt && we_q) begin
      rsp_rd_d   = '0;
      rsp_data_d = '0;
    end
    if (state_q == WAIT && mem_rvalid) begin
      rsp_rd_d   = rd_q;
      rsp_data_d = load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      rd_q       <= '0;
      rsp_rd_q   <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      rd_q       <= rd_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu - self-checking bench for riscv_lsu.
//
// Inputs change and outputs are sampled on the falling clock edge. Expected
// values come from a size/alignment model of RV32I loads and stores written
// with plain arithmetic, plus a few hand-computed constants for the
// directed cases.

module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  riscv_lsu #(.WORD_LENGTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rd     (rsp_rd),
    .rsp_data   (rsp_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Access size in bytes implied by the low two funct3 bits.
  function automatic int opSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit modelLegal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = opSize(f3);
    if (f3[1:0] == 2'b11) return 1'b0;
    if (we && f3[2]) return 1'b0;
    if (!we && f3 == 3'b110) return 1'b0;
    return (int'(addr[1:0]) % size) == 0;
  endfunction

  function automatic logic [3:0] modelBe(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int mask;
    if (!we) return 4'hF;
    mask = ((1 << opSize(f3)) - 1) << addr[1:0];
    return mask[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] r;
    int size;
    size = opSize(f3);
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = rs2[8*(k % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int size;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] v;
    size = opSize(f3);
    if (size == 4) return rdata;
    shifted = rdata >> (8 * int'(addr[1:0]));
    mask = 32'((1 << (8 * size)) - 1);
    v = shifted & mask;
    if (!f3[2] && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit valid, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = valid;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
  endtask

  // Runs one complete request from issue to idle, checking every cycle.
  task automatic doOp(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd,
                      input int gntDelay, input int rvDelay, input logic [31:0] rdata,
                      input bit useExp, input logic [31:0] expData);
    logic [31:0] expLoad;
    expLoad = useExp ? expData : modelLoad(f3, addr, rdata);
    checkOutput("ready_before_issue", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, we, f3, addr, wdata, rd);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    if (!modelLegal(we, f3, addr)) begin
      checkOutput("illegal_err", 32'(err), 32'd1);
      checkOutput("illegal_no_req", 32'(mem_req), 32'd0);
      checkOutput("illegal_ready", 32'(req_ready), 32'd1);
      step();
      checkOutput("illegal_err_pulse", 32'(err), 32'd0);
      checkOutput("illegal_no_req_later", 32'(mem_req), 32'd0);
      return;
    end
    checkOutput("legal_no_err", 32'(err), 32'd0);
    for (int i = 0; i <= gntDelay; i++) begin
      checkOutput("req_mem_req", 32'(mem_req), 32'd1);
      checkOutput("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
      checkOutput("req_be", 32'(mem_be), 32'(modelBe(we, f3, addr)));
      checkOutput("req_we", 32'(mem_we), 32'(we));
      if (we) checkOutput("req_wdata", mem_wdata, modelWdata(f3, wdata));
      checkOutput("req_ready_low", 32'(req_ready), 32'd0);
      checkOutput("req_no_rsp", 32'(rsp_valid), 32'd0);
      if (i < gntDelay) begin
        mem_gnt = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0F00, 32'd0, 5'd3);
      end else begin
        mem_gnt = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
      end
      step();
    end
    mem_gnt = 1'b0;
    if (!we) begin
      for (int i = 0; i < rvDelay; i++) begin
        checkOutput("wait_no_req", 32'(mem_req), 32'd0);
        checkOutput("wait_no_rsp", 32'(rsp_valid), 32'd0);
        step();
      end
      checkOutput("wait_no_req_final", 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_rd", 32'(rsp_rd), we ? 32'd0 : 32'(rd));
    checkOutput("rsp_data", rsp_data, we ? 32'd0 : expLoad);
    checkOutput("rsp_ready_low", 32'(req_ready), 32'd0);
    checkOutput("rsp_no_req", 32'(mem_req), 32'd0);
    step();
    checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit          rWe;
    logic [2:0]  rF3;
    logic [31:0] rAddr;
    logic [31:0] rData;
    logic [4:0]  rRd;

    rst_n      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) step();

    $display("[TB] reset state");
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    step();

    $display("[TB] directed loads");
    doOp(1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    doOp(1'b0, 3'b000, 32'h100, 32'd0, 5'd6, 0, 0, 32'h80017F80, 1'b1, 32'hFFFFFF80);
    doOp(1'b0, 3'b100, 32'h100, 32'd0, 5'd7, 0, 1, 32'h80017F80, 1'b1, 32'h00000080);
    doOp(1'b0, 3'b001, 32'h102, 32'd0, 5'd8, 1, 0, 32'h80017F80, 1'b1, 32'hFFFF8001);
    doOp(1'b0, 3'b101, 32'h100, 32'd0, 5'd9, 0, 2, 32'h80017F80, 1'b1, 32'h00007F80);

    $display("[TB] directed stores");
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000AB, 5'd12);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    checkOutput("sb_addr", mem_addr, 32'h100);
    checkOutput("sb_be", 32'(mem_be), 32'b0010);
    checkOutput("sb_wdata", mem_wdata, 32'hABABABAB);
    checkOutput("sb_we", 32'(mem_we), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("sb_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("sb_rsp_rd", 32'(rsp_rd), 32'd0);
    step();
    doOp(1'b1, 3'b010, 32'h204, 32'h12345678, 5'd3, 3, 0, 32'd0, 1'b0, 32'd0);
    doOp(1'b1, 3'b001, 32'h206, 32'h0000BEEF, 5'd4, 0, 0, 32'd0, 1'b0, 32'd0);

    $display("[TB] illegal requests");
    doOp(1'b0, 3'b010, 32'h102, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 32'd0);
    doOp(1'b1, 3'b001, 32'h103, 32'hFFFF, 5'd1, 0, 0, 32'd0, 1'b0, 32'd0);
    doOp(1'b0, 3'b011, 32'h100, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 32'd0);
    doOp(1'b1, 3'b100, 32'h100, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 32'd0);

    $display("[TB] load withheld grant");
    doOp(1'b0, 3'b001, 32'h3002, 32'd0, 5'd17, 3, 1, 32'hCAFE1234, 1'b1, 32'hFFFFCAFE);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd7);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    checkOutput("rw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("rw_wait_no_req", 32'(mem_req), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("rw_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("rw_no_req", 32'(mem_req), 32'd0);
    checkOutput("rw_no_rsp", 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    step();
    mem_rvalid = 1'b0;
    checkOutput("rw_stray_rvalid", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("rw_stray_rvalid_late", 32'(rsp_valid), 32'd0);
    doOp(1'b0, 3'b010, 32'h400, 32'd0, 5'd2, 0, 0, 32'h0BADF00D, 1'b1, 32'h0BADF00D);

    $display("[TB] randomized requests");
    for (int n = 0; n < 60; n++) begin
      rWe   = 1'($urandom_range(0, 1));
      rF3   = 3'($urandom_range(0, 7));
      rAddr = $urandom;
      rData = $urandom;
      rRd   = 5'($urandom_range(0, 31));
      doOp(rWe, rF3, rAddr, rData, rRd, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           $urandom, 1'b0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
